// File: rtl/ser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ser_pkg
//  Description : Shared types and constants for the serial transmitter.
//  Revision    : 1.0  - initial release
// ============================================================================
package ser_pkg;

  // Frame sequencer states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } ser_state_t;

  // Line levels for the idle/stop condition and the start bit
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Bits needed for a down-counter covering n distinct values (0..n-1), minimum 1
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ser_tx_baud.sv
`default_nettype none
// ============================================================================
//  Module      : ser_tx_baud
//  Description : Bit-period timer. Reloads DIV-1 on restart and counts down
//                to zero, where it holds; tick marks the last cycle of a period.
//  Revision    : 1.0  - initial release
// ============================================================================
module ser_tx_baud
  import ser_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic c,
  input  logic rstn,
  input  logic restart,
  output logic tick
);

  localparam int            CW         = cnt_width(DIV);
  localparam logic [CW-1:0] PERIOD_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: reload on restart, otherwise count down and saturate at zero
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = PERIOD_MAX;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Period counter register
  always_ff @(posedge c or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // With DIV=1 the counter is pinned at zero, so every cycle ends a period
  assign tick = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/ser_tx_logic.sv
`default_nettype none
// ============================================================================
//  Module      : ser_tx_logic
//  Description : Parallel-in, serial-out frame transmitter:
//                start bit, WIDTH data bits LSB-first, optional even parity,
//                stop bit. Every state lasts DIV clock cycles.
//  Revision    : 1.0  - initial release
// ============================================================================
module ser_tx_logic
  import ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter int PARITY_EN = 1
) (
  input  logic             c,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  input  logic             valid,
  output logic             ready,
  output logic             sdo,
  output logic             busy,
  output logic             done
);

  // tmrg default triplicate

  localparam int            BW      = cnt_width(WIDTH);
  localparam logic [BW-1:0] BIT_MAX = BW'(WIDTH - 1);

  ser_state_t       state_q,  state_d;
  logic [WIDTH-1:0] shreg_q,  shreg_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic             par_q,    par_d;
  logic             sdo_q,    sdo_d;
  logic             ready_q,  ready_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic             restart;
  logic             tick;
  logic [WIDTH-1:0] shreg_shift;

  assign shreg_shift = shreg_q >> 1;

  ser_tx_baud #(
    .DIV (DIV)
  ) u_baud (
    .c       (c),
    .rstn    (rstn),
    .restart (restart),
    .tick    (tick)
  );

  // Next-state logic; sdo is computed for the upcoming state so the line is registered
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    par_d    = par_q;
    sdo_d    = sdo_q;
    done_d   = 1'b0;
    restart  = 1'b0;

    case (state_q)
      IDLE: begin
        sdo_d = IDLE_LEVEL;
        if (valid) begin
          state_d  = START;
          shreg_d  = din;
          bitcnt_d = BIT_MAX;
          par_d    = ^din;
          sdo_d    = START_LEVEL;
          restart  = 1'b1;
        end
      end

      START: begin
        if (tick) begin
          state_d = DATA;
          sdo_d   = shreg_q[0];
          restart = 1'b1;
        end
      end

      DATA: begin
        if (tick) begin
          restart = 1'b1;
          if (bitcnt_q == '0) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              sdo_d   = par_q;
            end else begin
              state_d = STOP;
              sdo_d   = IDLE_LEVEL;
            end
          end else begin
            shreg_d  = shreg_shift;
            bitcnt_d = bitcnt_q - BW'(1);
            sdo_d    = shreg_shift[0];
          end
        end
      end

      PARITY: begin
        if (tick) begin
          state_d = STOP;
          sdo_d   = IDLE_LEVEL;
          restart = 1'b1;
        end
      end

      STOP: begin
        if (tick) begin
          state_d = IDLE;
          sdo_d   = IDLE_LEVEL;
          done_d  = 1'b1;
          restart = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        sdo_d   = IDLE_LEVEL;
      end
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = ~ready_d;
  end

  // State and output registers; reset aborts any frame without a done pulse
  always_ff @(posedge c or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      par_q    <= 1'b0;
      sdo_q    <= IDLE_LEVEL;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      par_q    <= par_d;
      sdo_q    <= sdo_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ready = ready_q;
  assign sdo   = sdo_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ser_tx_logic.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ser_tx_logic
//  Description : Directed self-checking bench for ser_tx_logic.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_ser_tx_logic;

  logic       clk;
  logic       rstn;

  // Instance A: WIDTH=8, DIV=4, parity on
  logic [7:0] din_a;
  logic       valid_a, ready_a, sdo_a, busy_a, done_a;
  // Instance B: WIDTH=8, DIV=4, parity off
  logic [7:0] din_b;
  logic       valid_b, ready_b, sdo_b, busy_b, done_b;
  // Instance C: WIDTH=1, DIV=1, parity on
  logic [0:0] din_c;
  logic       valid_c, ready_c, sdo_c, busy_c, done_c;

  int tests_run;
  int tests_failed;

  ser_tx_logic #(.WIDTH(8), .DIV(4), .PARITY_EN(1)) u_dut_a (
    .c(clk), .rstn(rstn), .din(din_a), .valid(valid_a),
    .ready(ready_a), .sdo(sdo_a), .busy(busy_a), .done(done_a)
  );

  ser_tx_logic #(.WIDTH(8), .DIV(4), .PARITY_EN(0)) u_dut_b (
    .c(clk), .rstn(rstn), .din(din_b), .valid(valid_b),
    .ready(ready_b), .sdo(sdo_b), .busy(busy_b), .done(done_b)
  );

  ser_tx_logic #(.WIDTH(1), .DIV(1), .PARITY_EN(1)) u_dut_c (
    .c(clk), .rstn(rstn), .din(din_c), .valid(valid_c),
    .ready(ready_c), .sdo(sdo_c), .busy(busy_c), .done(done_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset values on all three instances, held and after release
  task automatic test_reset();
    rstn = 1'b0;
    din_a = 8'h00; valid_a = 1'b0;
    din_b = 8'h00; valid_b = 1'b0;
    din_c = 1'b0;  valid_c = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({sdo_a, ready_a, busy_a, done_a} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL reset_a got sdo/ready/busy/done=%b want 1100", {sdo_a, ready_a, busy_a, done_a});
    end
    tests_run++;
    if ({sdo_b, ready_b, busy_b, done_b} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL reset_b got sdo/ready/busy/done=%b want 1100", {sdo_b, ready_b, busy_b, done_b});
    end
    tests_run++;
    if ({sdo_c, ready_c, busy_c, done_c} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL reset_c got sdo/ready/busy/done=%b want 1100", {sdo_c, ready_c, busy_c, done_c});
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({sdo_a, ready_a, busy_a, done_a} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL reset_release_a got sdo/ready/busy/done=%b want 1100", {sdo_a, ready_a, busy_a, done_a});
    end
  endtask

  // 0xA5 with parity: 11 bits x 4 cycles, done on cycle 45
  task automatic test_frame_parity();
    logic [10:0] exp;
    exp = 11'b1_0_10100101_0;   // stop, parity, data MSB..LSB, start
    @(negedge clk); din_a = 8'hA5; valid_a = 1'b1;
    @(negedge clk); valid_a = 1'b0; din_a = 8'h00;
    for (int k = 0; k < 44; k++) begin
      if (k > 0) @(negedge clk);
      tests_run++;
      if (sdo_a !== exp[k/4] || busy_a !== 1'b1 || ready_a !== 1'b0 || done_a !== 1'b0) begin
        tests_failed++;
        $display("FAIL a5_bit cyc=%0d got sdo=%b busy=%b ready=%b done=%b want sdo=%b busy=1 ready=0 done=0",
                 k + 1, sdo_a, busy_a, ready_a, done_a, exp[k/4]);
      end
    end
    @(negedge clk);
    tests_run++;
    if (done_a !== 1'b1 || ready_a !== 1'b1 || sdo_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL a5_done cyc=45 got done=%b ready=%b sdo=%b want 1 1 1", done_a, ready_a, sdo_a);
    end
    @(negedge clk);
    tests_run++;
    if (done_a !== 1'b0 || ready_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL a5_done_width cyc=46 got done=%b ready=%b want 0 1", done_a, ready_a);
    end
  endtask

  // 0xA5 without parity: 10 bits x 4 cycles, done on cycle 41
  task automatic test_frame_no_parity();
    logic [9:0] exp;
    exp = 10'b1_10100101_0;
    @(negedge clk); din_b = 8'hA5; valid_b = 1'b1;
    @(negedge clk); valid_b = 1'b0; din_b = 8'h00;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      tests_run++;
      if (sdo_b !== exp[k/4] || busy_b !== 1'b1 || done_b !== 1'b0) begin
        tests_failed++;
        $display("FAIL nopar_bit cyc=%0d got sdo=%b busy=%b done=%b want sdo=%b busy=1 done=0",
                 k + 1, sdo_b, busy_b, done_b, exp[k/4]);
      end
    end
    @(negedge clk);
    tests_run++;
    if (done_b !== 1'b1 || ready_b !== 1'b1 || sdo_b !== 1'b1) begin
      tests_failed++;
      $display("FAIL nopar_done cyc=41 got done=%b ready=%b sdo=%b want 1 1 1", done_b, ready_b, sdo_b);
    end
  endtask

  // valid held high: 0x3C then 0xC3 with exactly one idle cycle between
  task automatic test_back_to_back();
    logic [10:0] exp1;
    logic [10:0] exp2;
    exp1 = 11'b1_0_00111100_0;
    exp2 = 11'b1_0_11000011_0;
    @(negedge clk); din_a = 8'h3C; valid_a = 1'b1;
    @(negedge clk); din_a = 8'hC3;
    for (int k = 0; k < 44; k++) begin
      if (k > 0) @(negedge clk);
      tests_run++;
      if (sdo_a !== exp1[k/4] || busy_a !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_f1 cyc=%0d got sdo=%b busy=%b want sdo=%b busy=1", k + 1, sdo_a, busy_a, exp1[k/4]);
      end
    end
    @(negedge clk);
    tests_run++;
    if (ready_a !== 1'b1 || done_a !== 1'b1 || sdo_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_gap cyc=45 got ready=%b done=%b sdo=%b want 1 1 1", ready_a, done_a, sdo_a);
    end
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      if (k == 0) valid_a = 1'b0;
      tests_run++;
      if (sdo_a !== exp2[k/4] || busy_a !== 1'b1 || done_a !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_f2 cyc=%0d got sdo=%b busy=%b done=%b want sdo=%b busy=1 done=0",
                 k + 1, sdo_a, busy_a, done_a, exp2[k/4]);
      end
    end
    @(negedge clk);
    tests_run++;
    if (done_a !== 1'b1 || ready_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_done2 got done=%b ready=%b want 1 1", done_a, ready_a);
    end
  endtask

  // Reset during data bit 3 aborts silently; next frame 0xFF is clean
  task automatic test_reset_mid_frame();
    logic [10:0] exp;
    exp = 11'b1_0_11111111_0;
    @(negedge clk); din_a = 8'h5A; valid_a = 1'b1;
    @(negedge clk); valid_a = 1'b0;
    for (int k = 1; k < 18; k++) @(negedge clk);
    // cycle 18 lies in data bit 3 (cycles 17..20); 0x5A bit 3 is 1
    tests_run++;
    if (sdo_a !== 1'b1 || busy_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_pre got sdo=%b busy=%b want 1 1", sdo_a, busy_a);
    end
    #2 rstn = 1'b0;
    #1;
    tests_run++;
    if ({sdo_a, ready_a, busy_a, done_a} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL rstmid_async got sdo/ready/busy/done=%b want 1100", {sdo_a, ready_a, busy_a, done_a});
    end
    @(negedge clk); rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++;
      if ({sdo_a, ready_a, busy_a, done_a} !== 4'b1100) begin
        tests_failed++;
        $display("FAIL rstmid_after k=%0d got sdo/ready/busy/done=%b want 1100", k, {sdo_a, ready_a, busy_a, done_a});
      end
    end
    din_a = 8'hFF; valid_a = 1'b1;
    @(negedge clk); valid_a = 1'b0;
    for (int k = 0; k < 44; k++) begin
      if (k > 0) @(negedge clk);
      tests_run++;
      if (sdo_a !== exp[k/4] || busy_a !== 1'b1) begin
        tests_failed++;
        $display("FAIL rstmid_ff cyc=%0d got sdo=%b busy=%b want sdo=%b busy=1", k + 1, sdo_a, busy_a, exp[k/4]);
      end
    end
    @(negedge clk);
    tests_run++;
    if (done_a !== 1'b1 || ready_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_ff_done got done=%b ready=%b want 1 1", done_a, ready_a);
    end
  endtask

  // WIDTH=1, DIV=1, din=1: start 0, data 1, parity 1, stop 1, then idle
  task automatic test_div1();
    logic [3:0] exp;
    exp = 4'b1110;
    @(negedge clk); din_c = 1'b1; valid_c = 1'b1;
    @(negedge clk); valid_c = 1'b0; din_c = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      tests_run++;
      if (sdo_c !== exp[k] || busy_c !== 1'b1 || ready_c !== 1'b0) begin
        tests_failed++;
        $display("FAIL div1_bit cyc=%0d got sdo=%b busy=%b ready=%b want sdo=%b busy=1 ready=0",
                 k + 1, sdo_c, busy_c, ready_c, exp[k]);
      end
    end
    @(negedge clk);
    tests_run++;
    if (ready_c !== 1'b1 || done_c !== 1'b1 || sdo_c !== 1'b1) begin
      tests_failed++;
      $display("FAIL div1_end got ready=%b done=%b sdo=%b want 1 1 1", ready_c, done_c, sdo_c);
    end
  endtask

  // din and valid churn while busy must not disturb the latched 0x96
  task automatic test_din_while_busy();
    logic [10:0] exp;
    exp = 11'b1_0_10010110_0;
    @(negedge clk); din_a = 8'h96; valid_a = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 44; k++) begin
      if (k > 0) @(negedge clk);
      din_a   = 8'($urandom);
      valid_a = (k < 40) ? 1'($urandom) : 1'b0;
      tests_run++;
      if (sdo_a !== exp[k/4] || busy_a !== 1'b1) begin
        tests_failed++;
        $display("FAIL churn_bit cyc=%0d got sdo=%b busy=%b want sdo=%b busy=1", k + 1, sdo_a, busy_a, exp[k/4]);
      end
    end
    @(negedge clk);
    tests_run++;
    if (done_a !== 1'b1 || ready_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL churn_done got done=%b ready=%b want 1 1", done_a, ready_a);
    end
    @(negedge clk);
    tests_run++;
    if (ready_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL churn_idle got ready=%b busy=%b done=%b want 1 0 0", ready_a, busy_a, done_a);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_frame_parity();
    test_frame_no_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_div1();
    test_din_while_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
